// File: rtl/icache_pkg.sv
// Shared utilities for the instruction cache and the blocks around it.
// Holds the common address/word types, boolean constants, the cache
// geometry (also used by the memory controller arbiter) and the refill FSM
// state encoding.
package icache_pkg;

  typedef logic [31:0] ADDR_TP;
  typedef logic [31:0] WORD_TP;

  localparam ADDR_TP ZERO_ADDR = '0;
  localparam logic   TRUE      = 1'b1;
  localparam logic   FALSE     = 1'b0;

  // Geometry: 64 direct-mapped lines of 4 words each.
  localparam int ICACHE_INDEX_WIDTH    = 6;
  localparam int ICACHE_LINE_WORDS_LOG = 2;
  localparam int ICACHE_OFFSET_LSB     = 2;
  localparam int ICACHE_INDEX_LSB      = ICACHE_OFFSET_LSB + ICACHE_LINE_WORDS_LOG;
  localparam int ICACHE_TAG_LSB        = ICACHE_INDEX_LSB + ICACHE_INDEX_WIDTH;
  localparam int ICACHE_TAG_WIDTH      = 32 - ICACHE_TAG_LSB;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } icache_state_e;

  // Clears the low lsb bits of an address (line base computation).
  function automatic ADDR_TP align_down(input ADDR_TP a, input int unsigned lsb);
    return (a >> lsb) << lsb;
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Register based so the read port is purely combinational.
//
// Ports:
//   clk, rst                    clock, async active-low reset (clears valid only)
//   rd_index/rd_offset          combinational read port address
//   rd_valid/rd_tag/rd_data     read port results
//   wr_en/wr_index/wr_offset/wr_data   single-word data write
//   clr_en/clr_index/clr_tag    invalidate a line and install its new tag
//   set_en/set_index            mark a line valid
module icache_line_array
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH    = ICACHE_INDEX_WIDTH,
  parameter int LINE_WORDS_LOG = ICACHE_LINE_WORDS_LOG,
  parameter int TAG_WIDTH      = ICACHE_TAG_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [INDEX_WIDTH-1:0]    rd_index,
  input  logic [LINE_WORDS_LOG-1:0] rd_offset,
  output logic                      rd_valid,
  output logic [TAG_WIDTH-1:0]      rd_tag,
  output WORD_TP                    rd_data,
  input  logic                      wr_en,
  input  logic [INDEX_WIDTH-1:0]    wr_index,
  input  logic [LINE_WORDS_LOG-1:0] wr_offset,
  input  WORD_TP                    wr_data,
  input  logic                      clr_en,
  input  logic [INDEX_WIDTH-1:0]    clr_index,
  input  logic [TAG_WIDTH-1:0]      clr_tag,
  input  logic                      set_en,
  input  logic [INDEX_WIDTH-1:0]    set_index
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int WORDS = 1 << LINE_WORDS_LOG;

  logic [LINES-1:0]     valid_q, valid_d;
  logic [TAG_WIDTH-1:0] tag_q  [LINES];
  logic [TAG_WIDTH-1:0] tag_d  [LINES];
  WORD_TP               data_q [LINES][WORDS];
  WORD_TP               data_d [LINES][WORDS];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (clr_en) begin
      valid_d[clr_index] = FALSE;
      tag_d[clr_index]   = clr_tag;
    end
    // Set-valid is applied after clear so it wins if both hit one line.
    if (set_en) begin
      valid_d[set_index] = TRUE;
    end
    if (wr_en) begin
      data_d[wr_index][wr_offset] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data contents are meaningless while the valid bit is clear,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index][rd_offset];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache in front of the fetcher.
// Same-cycle combinational lookup; misses refill a whole line word by word
// from the memory controller while hits to other lines keep being served.
//
// Ports:
//   clk, rst        clock, async active-low reset
//   rdy             global ready; all state holds while low
//   if_rd_en        fetcher lookup enable
//   if_rd_addr      fetcher PC (byte address, word aligned)
//   if_hit          combinational hit
//   if_hit_inst     instruction for if_rd_addr, valid when if_hit
//   mc_req/mc_addr  registered word read request to the memory controller
//   mc_ack/mc_data  returned word for mc_addr
//
// FSM states:
//   state     | meaning
//   ST_IDLE   | no refill in flight; a lookup miss starts one
//   ST_REFILL | fetching line words base+4*cnt; other misses are ignored
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH    = ICACHE_INDEX_WIDTH,
  parameter int LINE_WORDS_LOG = ICACHE_LINE_WORDS_LOG
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   rdy,
  input  logic   if_rd_en,
  input  ADDR_TP if_rd_addr,
  output logic   if_hit,
  output WORD_TP if_hit_inst,
  output logic   mc_req,
  output ADDR_TP mc_addr,
  input  logic   mc_ack,
  input  WORD_TP mc_data
);

  localparam int OFF_LSB   = ICACHE_OFFSET_LSB;
  localparam int IDX_LSB   = OFF_LSB + LINE_WORDS_LOG;
  localparam int TAG_LSB   = IDX_LSB + INDEX_WIDTH;
  localparam int TAG_WIDTH = 32 - TAG_LSB;

  localparam logic [LINE_WORDS_LOG-1:0] CNT_LAST = '1;

  icache_state_e             state_q, state_d;
  logic [LINE_WORDS_LOG-1:0] cnt_q, cnt_d;
  ADDR_TP                    base_q, base_d;
  logic                      mc_req_q, mc_req_d;
  ADDR_TP                    mc_addr_q, mc_addr_d;

  logic [LINE_WORDS_LOG-1:0] lk_offset;
  logic [INDEX_WIDTH-1:0]    lk_index;
  logic [TAG_WIDTH-1:0]      lk_tag;
  logic [INDEX_WIDTH-1:0]    rf_index;
  logic                      rd_valid;
  logic [TAG_WIDTH-1:0]      rd_tag;
  WORD_TP                    rd_data;
  logic                      lk_match;
  logic                      wr_en, clr_en, set_en;
  logic [1:0]                unused_byte_bits;

  assign lk_offset        = if_rd_addr[IDX_LSB-1:OFF_LSB];
  assign lk_index         = if_rd_addr[TAG_LSB-1:IDX_LSB];
  assign lk_tag           = if_rd_addr[31:TAG_LSB];
  assign rf_index         = base_q[TAG_LSB-1:IDX_LSB];
  assign unused_byte_bits = if_rd_addr[1:0];

  icache_line_array #(
    .INDEX_WIDTH    (INDEX_WIDTH),
    .LINE_WORDS_LOG (LINE_WORDS_LOG),
    .TAG_WIDTH      (TAG_WIDTH)
  ) u_lines (
    .clk       (clk),
    .rst       (rst),
    .rd_index  (lk_index),
    .rd_offset (lk_offset),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_index  (rf_index),
    .wr_offset (cnt_q),
    .wr_data   (mc_data),
    .clr_en    (clr_en),
    .clr_index (lk_index),
    .clr_tag   (lk_tag),
    .set_en    (set_en),
    .set_index (rf_index)
  );

  assign lk_match    = rd_valid && (rd_tag == lk_tag);
  // Gating with rst keeps the hit low during reset independent of array timing.
  assign if_hit      = rst && if_rd_en && lk_match;
  assign if_hit_inst = rd_data;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    mc_req_d  = mc_req_q;
    mc_addr_d = mc_addr_q;
    wr_en     = FALSE;
    clr_en    = FALSE;
    set_en    = FALSE;
    if (rdy) begin
      case (state_q)
        ST_IDLE: begin
          if (if_rd_en && !lk_match) begin
            state_d   = ST_REFILL;
            base_d    = align_down(if_rd_addr, IDX_LSB);
            cnt_d     = '0;
            mc_req_d  = TRUE;
            mc_addr_d = base_d;
            clr_en    = TRUE;
          end
        end
        ST_REFILL: begin
          if (mc_ack) begin
            wr_en = TRUE;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              set_en   = TRUE;
              mc_req_d = FALSE;
              state_d  = ST_IDLE;
            end else begin
              // Base has its offset bits clear, so OR-ing cannot carry into the index.
              mc_addr_d = base_q | (ADDR_TP'(cnt_d) << OFF_LSB);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      base_q    <= ZERO_ADDR;
      mc_req_q  <= FALSE;
      mc_addr_q <= ZERO_ADDR;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      mc_req_q  <= mc_req_d;
      mc_addr_q <= mc_addr_d;
    end
  end

  assign mc_req  = mc_req_q;
  assign mc_addr = mc_addr_q;

endmodule

// File: tb/tb_icache.sv
module tb_icache;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        if_rd_en;
  logic [31:0] if_rd_addr;
  logic        if_hit;
  logic [31:0] if_hit_inst;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_ack;
  logic [31:0] mc_data;

  int n_chk  = 0;
  int n_fail = 0;

  icache dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .if_rd_en    (if_rd_en),
    .if_rd_addr  (if_rd_addr),
    .if_hit      (if_hit),
    .if_hit_inst (if_hit_inst),
    .mc_req      (mc_req),
    .mc_addr     (mc_addr),
    .mc_ack      (mc_ack),
    .mc_data     (mc_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Backing memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0: return 32'h0000_0013;
      32'h4: return 32'h0010_0093;
      32'h8: return 32'h0020_0113;
      32'hC: return 32'h0030_0193;
      default: return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a lookup and check hit plus word.
  task automatic look_hit(input logic [31:0] a);
    if_rd_addr = a;
    #1;
    chk("hit", {31'd0, if_hit}, 32'd1);
    chk("inst", if_hit_inst, mem_word(a));
  endtask

  // Word i of the refill of line base: optional stall cycles, then one ack.
  task automatic ack_one(input logic [31:0] base, input int i, input int gap, input bit miss);
    for (int g = 0; g < gap; g++) begin
      chk("stall_req", {31'd0, mc_req}, 32'd1);
      chk("stall_addr", mc_addr, base + 32'(4 * i));
      tick();
    end
    chk("req", {31'd0, mc_req}, 32'd1);
    chk("mc_addr", mc_addr, base + 32'(4 * i));
    if (miss) chk("line_pending", {31'd0, if_hit}, 32'd0);
    mc_ack  = 1'b1;
    mc_data = mem_word(base + 32'(4 * i));
    tick();
    mc_ack  = 1'b0;
    mc_data = 32'h0;
  endtask

  task automatic ack_line(input logic [31:0] base, input bit miss);
    for (int i = 0; i < 4; i++) ack_one(base, i, 0, miss);
    chk("req_done", {31'd0, mc_req}, 32'd0);
  endtask

  // Present a missing address and let the refill start at the next edge.
  task automatic start_miss(input logic [31:0] a);
    if_rd_en   = 1'b1;
    if_rd_addr = a;
    #1;
    chk("miss", {31'd0, if_hit}, 32'd0);
    tick();
  endtask

  initial begin
    rst        = 1'b0;
    rdy        = 1'b1;
    if_rd_en   = 1'b1;
    if_rd_addr = 32'h0;
    mc_ack     = 1'b0;
    mc_data    = 32'h0;
    tick();
    tick();
    chk("rst_req", {31'd0, mc_req}, 32'd0);
    chk("rst_addr", mc_addr, 32'h0);
    chk("rst_hit", {31'd0, if_hit}, 32'd0);
    rst = 1'b1;

    // Cold miss on line 0.
    start_miss(32'h0);
    ack_line(32'h0, 1'b1);
    look_hit(32'h0);
    for (int i = 1; i < 4; i++) begin
      look_hit(32'(4 * i));
      tick();
      chk("no_new_req", {31'd0, mc_req}, 32'd0);
    end

    // Stray ack in IDLE, and lookup disabled on a missing line.
    mc_ack = 1'b1;
    tick();
    mc_ack = 1'b0;
    chk("idle_ack_req", {31'd0, mc_req}, 32'd0);
    if_rd_en   = 1'b0;
    if_rd_addr = 32'h60;
    #1;
    chk("en0_hit", {31'd0, if_hit}, 32'd0);
    tick();
    chk("en0_req", {31'd0, mc_req}, 32'd0);
    if_rd_en = 1'b1;

    // Conflict eviction on index 0.
    start_miss(32'h400);
    ack_line(32'h400, 1'b1);
    look_hit(32'h400);
    look_hit(32'h40C);
    start_miss(32'h0);
    ack_line(32'h0, 1'b1);
    look_hit(32'h0);

    // Hit-under-miss while line 0x10 waits for its first ack.
    start_miss(32'h10);
    for (int c = 0; c < 3; c++) begin
      look_hit(32'h4);
      if_rd_addr = 32'h10;
      #1;
      chk("hum_pending", {31'd0, if_hit}, 32'd0);
      chk("hum_req", {31'd0, mc_req}, 32'd1);
      chk("hum_addr", mc_addr, 32'h10);
      if_rd_addr = (c == 1) ? 32'h30 : 32'h10;
      tick();
    end
    if_rd_addr = 32'h10;
    #1;
    chk("hum_other_miss_ignored", mc_addr, 32'h10);
    ack_line(32'h10, 1'b1);
    look_hit(32'h10);
    look_hit(32'h1C);

    // Ack stalls and rdy drop on line 0x50.
    start_miss(32'h50);
    ack_one(32'h50, 0, 3, 1'b1);
    ack_one(32'h50, 1, 3, 1'b1);
    rdy    = 1'b0;
    mc_ack = 1'b1;
    mc_data = 32'hDEAD_BEEF;
    tick();
    tick();
    mc_ack = 1'b0;
    chk("rdy0_req", {31'd0, mc_req}, 32'd1);
    chk("rdy0_addr", mc_addr, 32'h58);
    rdy = 1'b1;
    ack_one(32'h50, 2, 3, 1'b1);
    ack_one(32'h50, 3, 3, 1'b1);
    chk("stall_done", {31'd0, mc_req}, 32'd0);
    for (int i = 0; i < 4; i++) look_hit(32'h50 + 32'(4 * i));

    // PC change mid-refill: 0x20 completes, then 0x400 starts next cycle.
    start_miss(32'h20);
    ack_one(32'h20, 0, 0, 1'b1);
    if_rd_addr = 32'h400;
    for (int i = 1; i < 4; i++) ack_one(32'h20, i, 0, 1'b1);
    chk("pc_chg_idle", {31'd0, mc_req}, 32'd0);
    tick();
    chk("pc_chg_next_req", {31'd0, mc_req}, 32'd1);
    chk("pc_chg_next_addr", mc_addr, 32'h400);
    ack_line(32'h400, 1'b1);
    look_hit(32'h20);
    look_hit(32'h24);
    look_hit(32'h400);

    // Asynchronous reset mid-refill of line 0.
    start_miss(32'h0);
    ack_one(32'h0, 0, 0, 1'b1);
    ack_one(32'h0, 1, 0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req", {31'd0, mc_req}, 32'd0);
    chk("arst_addr", mc_addr, 32'h0);
    if_rd_addr = 32'h20;
    #1;
    chk("arst_hit", {31'd0, if_hit}, 32'd0);
    tick();
    rst = 1'b1;
    if_rd_addr = 32'h50;
    #1;
    chk("inval_50", {31'd0, if_hit}, 32'd0);
    if_rd_addr = 32'h10;
    #1;
    chk("inval_10", {31'd0, if_hit}, 32'd0);
    start_miss(32'h0);
    chk("restart_addr", mc_addr, 32'h0);
    ack_line(32'h0, 1'b1);
    look_hit(32'h0);
    look_hit(32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
